telemetry_tx_scheduler: RTL and testbench
=========================================

Name: telemetry_tx_scheduler

Overview:
- Shares one byte-wide UART transmitter between two frame sources.
- Source 1: a periodic telemetry frame carrying speed, distance and a status byte.
- Source 2: an event-driven alarm frame.
- The block times the periodic requests, arbitrates with alarm priority, snapshots the payload, appends a checksum and CR/LF, and drives the byte strobe/ready handshake toward the transmitter.

Parameters:
PERIOD_TICKS, 100, clk_1 cycles between periodic telemetry requests (>=2)

Ports:
clk_1  in  1  block clock; also the transmitter handshake clock
resetStatus  in  1  reset, asynchronous, active-high
enable  in  1  gates the periodic telemetry timer
speed  in  8  telemetry payload byte
distance  in  8  telemetry payload byte
direction  in  1  status bit 6
degree  in  9  tilt angle, unsigned
alarm_req  in  1  one-cycle alarm request
alarm_code  in  8  alarm payload, sampled with alarm_req
tx_ready  in  1  transmitter can accept a byte
tx_send  out  1  one-cycle byte strobe
tx_data  out  8  byte to transmit
busy  out  1  frame in progress (FSM not IDLE)
frame_cnt  out  8  completed frames, wraps 255->0
alarm_dropped  out  1  one-cycle pulse: alarm request lost

Behaviour:
- Reset: all outputs 0; timer 0; tel_pending/alarm_pending 0; FSM IDLE. Async assert aborts any frame immediately; a partial frame is never resumed.
- Timer:
  - enable=1: counts 0..PERIOD_TICKS-1; at wrap, sets tel_pending.
  - enable=0: held at 0.
  - A wrap while tel_pending=1 coalesces: no extra frame.
- Alarm:
  - alarm_req with alarm_pending=0: sets alarm_pending and latches alarm_code.
  - alarm_req with alarm_pending=1: alarm_dropped=1 for one cycle; latched code is unchanged.
  - Alarms are accepted regardless of enable, and while a frame (including an alarm frame) is being sent.
- Telemetry frame, 7 bytes: 0xA5, speed, distance, status, csum, 0x0D, 0x0A.
  - status = {1'b0, direction, tilt[1:0], 4'b1010}.
  - tilt = 2 if degree>100; else 1 if degree>80; else 0.
  - csum = (speed+distance+status) mod 256.
- Alarm frame, 5 bytes: 0x5A, code, code, 0x0D, 0x0A (the checksum byte equals code).
- FSM:
  - IDLE: if alarm_pending, go to SEND with alarm selected; else if tel_pending, go to SEND with telemetry selected.
  - On the leaving edge: clear the selected pending flag, snapshot payload inputs into the frame buffer, byte index=0. busy=1 from the next cycle.
  - SEND: when tx_ready=1, register tx_send=1 and tx_data=byte[index], then go to HOLD. If tx_ready=0, wait with tx_send=0 and tx_data held.
  - HOLD: one cycle, tx_ready ignored (the transmitter drops tx_ready within one cycle of the strobe).
  - From HOLD: if this was the last byte, go to DONE; else index+1 and return to SEND.
  - DONE: frame_cnt+1, busy=0, return to IDLE. The next frame can leave IDLE on the following cycle.
- Strobe spacing with tx_ready held high: 2 cycles. tx_data is stable from each strobe until the next strobe.
- Simultaneous alarm_req and timer wrap: alarm frame first, then telemetry. The telemetry snapshot is taken when that frame starts.
- Payload inputs changing mid-frame do not affect the bytes already sent or still queued for the current frame.

Test Plan:
1. PERIOD_TICKS=10, enable=1, tx_ready=1, speed=0x12, distance=0x34, direction=1, degree=90 -> bytes A5 12 34 5A A0 0D 0A. Strobes are 2 cycles apart. Then frame_cnt=1, busy=0.
2. direction=0, speed=0xFF, distance=0xFF; degree=101/100/80 -> status 0x2A/0x1A/0x0A. degree=80 gives csum 0x08 (wrap check).
3. alarm_req with code 0x3C on the same cycle as the timer wrap -> 5A 3C 3C 0D 0A, then the telemetry frame; frame_cnt advances by 2.
4. Hold tx_ready=0; alarm_req code 0x11, then alarm_req code 0x22 -> alarm_dropped pulses once. After tx_ready=1, only the 0x11 frame is sent.
5. Drop tx_ready for 20 cycles after byte 3 -> tx_send=0 and tx_data held throughout. Transmission resumes at byte 4 with no loss or duplication.
6. Assert resetStatus after byte 2 -> tx_send, busy and frame_cnt are 0 immediately. After release, nothing is sent until 10 cycles pass, then a full frame is sent.

Source files
------------

// File: rtl/telemetry_tx_scheduler.sv
// Purpose : shares one byte-wide UART transmitter between a periodic telemetry
//           frame (A5 spd dst status csum CR LF) and an event-driven alarm
//           frame (5A code code CR LF). Alarm frames take priority.
// Latency : a pending request leaves IDLE on the next edge. The first strobe
//           follows one cycle later. Strobes are 2 cycles apart while tx_ready=1.
// Backpr. : SEND waits while tx_ready=0, with tx_send=0 and tx_data held.
//           Requests arriving meanwhile stay pending. A second alarm arriving
//           while one is pending is dropped and alarm_dropped pulses.
// Ports   : clk_1/resetStatus (async, active-high); enable gates the period
//           timer; speed/distance/direction/degree form the telemetry payload;
//           alarm_req/alarm_code carry the alarm request; tx_ready/tx_send/
//           tx_data form the transmitter handshake; busy means a frame is in
//           progress; frame_cnt counts completed frames; alarm_dropped flags a
//           lost alarm.
module telemetry_tx_scheduler #(
  parameter int PERIOD_TICKS = 100
) (
  input  logic       clk_1,
  input  logic       resetStatus,
  input  logic       enable,
  input  logic [7:0] speed,
  input  logic [7:0] distance,
  input  logic       direction,
  input  logic [8:0] degree,
  input  logic       alarm_req,
  input  logic [7:0] alarm_code,
  input  logic       tx_ready,
  output logic       tx_send,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic [7:0] frame_cnt,
  output logic       alarm_dropped
);

  localparam int TW = $clog2(PERIOD_TICKS);

  typedef enum logic [1:0] {IDLE, SEND, HOLD, DONE} state_t;

  state_t          state, state_nxt;
  logic [TW-1:0]   timer;
  logic            timer_wrap;
  logic            tel_pending;
  logic            alarm_pending;
  logic [7:0]      alarm_code_q;
  logic [6:0][7:0] frame_buf;
  logic [2:0]      byte_idx;
  logic [2:0]      last_idx;
  logic            start;
  logic            start_alarm;
  logic [1:0]      tilt;
  logic [7:0]      status;
  logic [7:0]      csum;

  assign timer_wrap = enable && (timer == TW'(PERIOD_TICKS - 1));

  // The status byte and checksum come from the live inputs. They only matter
  // on the edge that leaves IDLE, when they are copied into frame_buf.
  always_comb begin
    tilt = 2'd0;
    if (degree > 9'd100)
      tilt = 2'd2;
    else if (degree > 9'd80)
      tilt = 2'd1;
  end

  assign status = {1'b0, direction, tilt, 4'b1010};
  assign csum   = speed + distance + status;

  assign busy = (state != IDLE);

  always_comb begin
    state_nxt   = state;
    start       = 1'b0;
    start_alarm = 1'b0;
    case (state)
      IDLE: begin
        if (alarm_pending) begin
          state_nxt   = SEND;
          start       = 1'b1;
          start_alarm = 1'b1;
        end else if (tel_pending) begin
          state_nxt = SEND;
          start     = 1'b1;
        end
      end
      SEND:    if (tx_ready) state_nxt = HOLD;
      // HOLD ignores tx_ready: the transmitter needs a cycle to drop it.
      HOLD:    state_nxt = (byte_idx == last_idx) ? DONE : SEND;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_1 or posedge resetStatus) begin
    if (resetStatus)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk_1 or posedge resetStatus) begin
    if (resetStatus) begin
      timer         <= '0;
      tel_pending   <= 1'b0;
      alarm_pending <= 1'b0;
      alarm_code_q  <= '0;
      frame_buf     <= '0;
      byte_idx      <= '0;
      last_idx      <= '0;
      tx_send       <= 1'b0;
      tx_data       <= '0;
      frame_cnt     <= '0;
      alarm_dropped <= 1'b0;
    end else begin
      tx_send <= 1'b0;

      if (!enable || timer_wrap)
        timer <= '0;
      else
        timer <= timer + 1'b1;

      // A wrap while a request is already pending coalesces into it.
      // A new wrap on the edge that consumes the flag keeps it set.
      if (timer_wrap)
        tel_pending <= 1'b1;
      else if (start && !start_alarm)
        tel_pending <= 1'b0;

      // The flag tested here is the pre-edge value. A request on the same edge
      // that consumes a pending alarm is therefore still treated as a drop.
      alarm_dropped <= alarm_req && alarm_pending;
      if (alarm_req && !alarm_pending) begin
        alarm_pending <= 1'b1;
        alarm_code_q  <= alarm_code;
      end else if (start_alarm) begin
        alarm_pending <= 1'b0;
      end

      if (start) begin
        byte_idx <= '0;
        if (start_alarm) begin
          frame_buf <= {16'h0000, 8'h0A, 8'h0D, alarm_code_q, alarm_code_q, 8'h5A};
          last_idx  <= 3'd4;
        end else begin
          frame_buf <= {8'h0A, 8'h0D, csum, status, distance, speed, 8'hA5};
          last_idx  <= 3'd6;
        end
      end

      if (state == SEND && tx_ready) begin
        tx_send <= 1'b1;
        tx_data <= frame_buf[byte_idx];
      end

      if (state == HOLD && byte_idx != last_idx)
        byte_idx <= byte_idx + 3'd1;

      if (state == DONE)
        frame_cnt <= frame_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_telemetry_tx_scheduler.sv
// Bench for telemetry_tx_scheduler (PERIOD_TICKS=10). Every cycle is compared
// against a request/frame-level reference model. Frame payload vectors come
// from a table, and the corner cases are hand-written sequences.
module tb_telemetry_tx_scheduler;
  localparam int P = 10;

  logic       clk_1 = 1'b0;
  logic       resetStatus = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] speed = '0;
  logic [7:0] distance = '0;
  logic       direction = 1'b0;
  logic [8:0] degree = '0;
  logic       alarm_req = 1'b0;
  logic [7:0] alarm_code = '0;
  logic       tx_ready = 1'b0;
  logic       tx_send;
  logic [7:0] tx_data;
  logic       busy;
  logic [7:0] frame_cnt;
  logic       alarm_dropped;

  always #5 clk_1 = ~clk_1;

  telemetry_tx_scheduler #(.PERIOD_TICKS(P)) dut (
    .clk_1(clk_1), .resetStatus(resetStatus), .enable(enable),
    .speed(speed), .distance(distance), .direction(direction), .degree(degree),
    .alarm_req(alarm_req), .alarm_code(alarm_code), .tx_ready(tx_ready),
    .tx_send(tx_send), .tx_data(tx_data), .busy(busy),
    .frame_cnt(frame_cnt), .alarm_dropped(alarm_dropped)
  );

  typedef struct packed { logic [3:0] len; logic [6:0][7:0] b; } frame_t;
  typedef struct { logic [7:0] sp; logic [7:0] di; logic dir; logic [8:0] deg;
                   logic [7:0] st; logic [7:0] cs; } vec_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model state
  int              m_t, m_idx, m_len, m_tail;
  bit              m_apend, m_tpend, m_busy, m_prev;
  logic [7:0]      m_acode, m_cnt, m_data;
  logic [6:0][7:0] m_frame;
  bit              e_send, e_drop;

  // Observed DUT traffic
  logic [7:0] dut_cur[$];
  frame_t     dut_log[$];
  int         strobe_cyc[$];
  bit         dut_busy_q;
  int         drop_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0][7:0] tel_frame(input logic [7:0] s, input logic [7:0] d,
                                                input logic dir, input logic [8:0] deg);
    logic [6:0][7:0] f;
    int tilt, st, sum;
    tilt = (deg > 100) ? 2 : ((deg > 80) ? 1 : 0);
    st   = 10 + 16 * tilt + 64 * int'(dir);
    sum  = int'(s) + int'(d) + st;
    f[0] = 8'hA5; f[1] = s; f[2] = d; f[3] = 8'(st);
    f[4] = 8'(sum % 256); f[5] = 8'h0D; f[6] = 8'h0A;
    return f;
  endfunction

  function automatic frame_t get_frame(input int i);
    if (i < dut_log.size()) return dut_log[i];
    return '0;
  endfunction

  task automatic model_reset();
    m_t = 0; m_idx = 0; m_len = 0; m_tail = 0;
    m_apend = 0; m_tpend = 0; m_busy = 0; m_prev = 0;
    m_acode = '0; m_cnt = '0; m_data = '0; m_frame = '0;
    dut_cur.delete(); dut_busy_q = 0;
  endtask

  // One clock: the inputs currently driven apply to the coming edge.
  task automatic tick();
    bit en, req, rdy, dir, busy_b, was_a, was_t, start, wrap;
    logic [7:0] sp, di, code;
    logic [8:0] deg;
    en = enable; req = alarm_req; rdy = tx_ready; dir = direction;
    sp = speed; di = distance; code = alarm_code; deg = degree;
    busy_b = m_busy; was_a = m_apend; was_t = m_tpend;
    @(posedge clk_1);
    cyc++;
    e_send = 0;
    if (m_tail > 0) begin
      // Trailing HOLD and DONE cycles after the last byte.
      m_tail--;
      if (m_tail == 0) begin m_busy = 0; m_cnt++; end
    end else if (busy_b && !m_prev && m_idx < m_len && rdy) begin
      e_send = 1; m_data = m_frame[m_idx]; m_idx++;
      if (m_idx == m_len) m_tail = 2;
    end
    m_prev = e_send;
    start = !busy_b && (was_a || was_t);
    if (start) begin
      m_busy = 1; m_idx = 0;
      if (was_a) begin
        m_frame = {16'h0, 8'h0A, 8'h0D, m_acode, m_acode, 8'h5A}; m_len = 5; m_apend = 0;
      end else begin
        m_frame = tel_frame(sp, di, dir, deg); m_len = 7; m_tpend = 0;
      end
    end
    e_drop = req && was_a;
    if (req && !was_a) begin m_apend = 1; m_acode = code; end
    wrap = 0;
    if (en) begin
      if (m_t == P - 1) begin m_t = 0; wrap = 1; end else m_t++;
    end else m_t = 0;
    if (wrap) m_tpend = 1;
    #1;
    chk("tx_send", tx_send, e_send);
    chk("tx_data", tx_data, m_data);
    chk("busy", busy, m_busy);
    chk("frame_cnt", frame_cnt, m_cnt);
    chk("alarm_dropped", alarm_dropped, e_drop);
    if (alarm_dropped) drop_cnt++;
    if (tx_send) begin dut_cur.push_back(tx_data); strobe_cyc.push_back(cyc); end
    if (dut_busy_q && !busy) begin
      frame_t f;
      f.len = 4'(dut_cur.size());
      f.b = '0;
      for (int i = 0; i < dut_cur.size() && i < 7; i++) f.b[i] = dut_cur[i];
      dut_log.push_back(f);
      dut_cur.delete();
    end
    dut_busy_q = busy;
  endtask

  task automatic apply_reset();
    resetStatus = 1'b1;
    model_reset();
    repeat (2) @(posedge clk_1);
    #1 resetStatus = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    enable = 0; alarm_req = 0; tx_ready = 1;
    while ((m_busy || m_apend || m_tpend) && n < 300) begin tick(); n++; end
    chk("drain_timeout", (m_busy || m_apend || m_tpend), 0);
    dut_log.delete(); dut_cur.delete(); strobe_cyc.delete();
  endtask

  task automatic wait_frames(input int n);
    int k = 0;
    while (dut_log.size() < n && k < 400) begin tick(); k++; end
    chk("frame_timeout", dut_log.size() >= n, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t   vt[5];
    frame_t f;
    logic [7:0] cnt0;
    int k;

    vt[0] = '{8'h12, 8'h34, 1'b1, 9'd90,  8'h5A, 8'hA0};
    vt[1] = '{8'hFF, 8'hFF, 1'b0, 9'd101, 8'h2A, 8'h28};
    vt[2] = '{8'hFF, 8'hFF, 1'b0, 9'd100, 8'h1A, 8'h18};
    vt[3] = '{8'hFF, 8'hFF, 1'b0, 9'd80,  8'h0A, 8'h08};
    vt[4] = '{8'h00, 8'h00, 1'b1, 9'd511, 8'h6A, 8'h6A};

    // Reset state
    #3;
    chk("rst_tx_send", tx_send, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_alarm_dropped", alarm_dropped, 0);
    apply_reset();

    // Telemetry payload table
    for (int i = 0; i < 5; i++) begin
      drain();
      speed = vt[i].sp; distance = vt[i].di; direction = vt[i].dir; degree = vt[i].deg;
      enable = 1; tx_ready = 1;
      wait_frames(1);
      enable = 0;
      f = get_frame(0);
      chk($sformatf("v%0d_len", i), f.len, 7);
      chk($sformatf("v%0d_hdr", i), f.b[0], 8'hA5);
      chk($sformatf("v%0d_speed", i), f.b[1], vt[i].sp);
      chk($sformatf("v%0d_dist", i), f.b[2], vt[i].di);
      chk($sformatf("v%0d_status", i), f.b[3], vt[i].st);
      chk($sformatf("v%0d_csum", i), f.b[4], vt[i].cs);
      chk($sformatf("v%0d_crlf", i), {f.b[6], f.b[5]}, 16'h0A0D);
      if (i == 0) begin
        chk("v0_frame_cnt", frame_cnt, 1);
        chk("v0_busy", busy, 0);
        chk("v0_strobes", strobe_cyc.size(), 7);
        for (int j = 1; j < strobe_cyc.size(); j++)
          chk("v0_spacing", strobe_cyc[j] - strobe_cyc[j-1], 2);
      end
    end

    // Alarm on the same edge as the timer wrap: alarm first, then telemetry
    // with the payload present when that frame starts.
    drain();
    speed = 8'h01; distance = 8'h02; direction = 0; degree = 9'd0; enable = 1;
    for (int j = 0; j < P && m_t != P - 1; j++) tick();
    cnt0 = m_cnt;
    alarm_req = 1; alarm_code = 8'h3C;
    tick();
    alarm_req = 0; enable = 0; speed = 8'h55;
    wait_frames(2);
    f = get_frame(0);
    chk("t3_alarm_len", f.len, 5);
    chk("t3_alarm_bytes", f.b, {16'h0, 8'h0A, 8'h0D, 8'h3C, 8'h3C, 8'h5A});
    f = get_frame(1);
    chk("t3_tel_len", f.len, 7);
    chk("t3_tel_bytes", f.b, {8'h0A, 8'h0D, 8'h61, 8'h0A, 8'h02, 8'h55, 8'hA5});
    chk("t3_frame_cnt", frame_cnt, 8'(cnt0 + 8'd2));

    // Back-to-back alarms while the transmitter is stalled
    drain();
    tx_ready = 0; drop_cnt = 0;
    alarm_req = 1; alarm_code = 8'h11; tick();
    alarm_code = 8'h22; tick();
    alarm_req = 0; alarm_code = 8'h99;
    repeat (20) tick();
    chk("t4_drop_cnt", drop_cnt, 1);
    chk("t4_nothing_sent", dut_cur.size(), 0);
    tx_ready = 1;
    wait_frames(1);
    repeat (30) tick();
    chk("t4_frames", dut_log.size(), 1);
    f = get_frame(0);
    chk("t4_alarm_bytes", f.b, {16'h0, 8'h0A, 8'h0D, 8'h11, 8'h11, 8'h5A});

    // Stall after the third byte
    drain();
    speed = 8'h40; distance = 8'h21; direction = 0; degree = 9'd0;
    enable = 1; tx_ready = 1;
    k = 0;
    while (dut_cur.size() < 3 && k < 100) begin tick(); k++; end
    chk("t5_reach_byte3", dut_cur.size(), 3);
    tx_ready = 0; enable = 0;
    for (int j = 0; j < 20; j++) begin
      tick();
      chk("t5_stall_send", tx_send, 0);
      chk("t5_stall_data", tx_data, 8'h21);
    end
    tx_ready = 1;
    wait_frames(1);
    f = get_frame(0);
    chk("t5_len", f.len, 7);
    chk("t5_bytes", f.b, {8'h0A, 8'h0D, 8'h6B, 8'h0A, 8'h21, 8'h40, 8'hA5});

    // Asynchronous reset mid-frame
    drain();
    speed = 8'h07; distance = 8'h08; direction = 1; degree = 9'd200;
    enable = 1; tx_ready = 1;
    k = 0;
    while (dut_cur.size() < 2 && k < 100) begin tick(); k++; end
    chk("t6_reach_byte2", dut_cur.size(), 2);
    #2 resetStatus = 1'b1;
    #1;
    chk("t6_rst_send", tx_send, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_cnt", frame_cnt, 0);
    model_reset();
    repeat (2) @(posedge clk_1);
    #1 resetStatus = 1'b0;
    dut_log.delete(); strobe_cyc.delete();
    for (int j = 0; j < 10; j++) begin
      tick();
      chk("t6_quiet_busy", busy, 0);
      chk("t6_quiet_send", tx_send, 0);
    end
    wait_frames(1);
    enable = 0;
    f = get_frame(0);
    chk("t6_len", f.len, 7);
    chk("t6_bytes", f.b, {8'h0A, 8'h0D, 8'h79, 8'h6A, 8'h08, 8'h07, 8'hA5});
    chk("t6_frame_cnt", frame_cnt, 1);

    // Randomized traffic against the model
    drain();
    for (int j = 0; j < 2500; j++) begin
      enable     = ($urandom_range(0, 9) != 0);
      tx_ready   = ($urandom_range(0, 9) < 7);
      alarm_req  = ($urandom_range(0, 19) == 0);
      alarm_code = 8'($urandom);
      speed      = 8'($urandom);
      distance   = 8'($urandom);
      direction  = 1'($urandom);
      degree     = ($urandom_range(0, 1) == 0) ? 9'($urandom_range(70, 110)) : 9'($urandom);
      tick();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
